nn_upscaler_stream: RTL

- Hardware nearest-neighbour integer upscaler that replaces bench-side pixel replication; the existing bench only repeats pixels before feeding top_upscaler.
- Accepts a raster pixel stream with valid/ready. Emits each pixel scale times horizontally and each row scale times vertically, with frame/line markers.
- Sits between the pixel source and the downstream filter/top_upscaler datapath. Scale is runtime-selectable up to MAX_SCALE.

---
 rtl/upscaler_pkg.sv | 28 ++
 rtl/nn_line_buffer.sv | 30 +++
 rtl/nn_upscaler_stream.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/upscaler_pkg.sv
// Shared types and sizing helpers for the nearest-neighbour upscaler and its line buffer.
package upscaler_pkg;

  typedef enum logic {
    FILL   = 1'b0,
    REPLAY = 1'b1
  } state_e;

  function automatic int pix_w(input int ch, input int ch_w);
    return ch * ch_w;
  endfunction

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int sel_w(input int max_scale);
    return $clog2(max_scale + 1);
  endfunction

  // A request of 0 means "no scaling"; anything beyond the supported range saturates.
  function automatic int clamp_scale(input int sel, input int max_scale);
    if (sel == 0) return 1;
    if (sel > max_scale) return max_scale;
    return sel;
  endfunction

endpackage

// File: rtl/nn_line_buffer.sv
// Single-row pixel store: one synchronous write port, one combinational read port.
module nn_line_buffer
  import upscaler_pkg::*;
#(
  parameter  int DEPTH = 128,
  parameter  int WIDTH = 24,
  localparam int AW    = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/nn_upscaler_stream.sv
// Nearest-neighbour integer upscaler: repeats every pixel and every row 'scale' times on a valid/ready stream.
// Defining NN_UPSCALER_FRAME_CNT_EN adds the frame_done pulse and frame_cnt ports.
module nn_upscaler_stream
  import upscaler_pkg::*;
#(
  parameter  int IMG_W     = 128,
  parameter  int IMG_H     = 72,
  parameter  int CH        = 3,
  parameter  int CH_W      = 8,
  parameter  int MAX_SCALE = 4,
  localparam int PIX_W     = pix_w(CH, CH_W),
  localparam int SEL_W     = sel_w(MAX_SCALE)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SEL_W-1:0] scale_sel,
  input  logic [PIX_W-1:0] in_pixel,
  input  logic             in_valid,
  input  logic             in_sof,
  output logic             in_ready,
  output logic [PIX_W-1:0] out_pixel,
  output logic             out_valid,
  output logic             out_sof,
  output logic             out_eol,
  input  logic             out_ready,
  output logic             sof_err
`ifdef NN_UPSCALER_FRAME_CNT_EN
  ,
  output logic             frame_done,
  output logic [15:0]      frame_cnt
`endif
);

  localparam int COL_W = cnt_w(IMG_W);
  localparam int ROW_W = cnt_w(IMG_H);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H - 1);

  state_e           state_q, state_d;
  logic [COL_W-1:0] col_q, col_d, col_cur;
  logic [ROW_W-1:0] row_q, row_d, row_cur;
  logic [SEL_W-1:0] hrep_q, hrep_d, hrep_inc;
  logic [SEL_W-1:0] vrep_q, vrep_d;
  logic [SEL_W-1:0] scale_q, scale_d, scale_cur, scale_in;
  logic [PIX_W-1:0] pix_q, pix_d, load_pix, rd_data;
  logic             valid_q, valid_d, sof_q, sof_d, eol_q, eol_d, err_q, err_d;
  logic             load_ok, accept, at_origin, frame_start, load, wrap, line_end;

  nn_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_line_buffer (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (accept),
    .wr_addr (col_cur),
    .wr_data (in_pixel),
    .rd_addr (col_q),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FILL;
    else        state_q <= state_d;
  end

  // hrep counts copies already loaded modulo scale, so hrep==0 means the register holds the final copy.
  always_comb begin
    load_ok     = !valid_q || out_ready;
    in_ready    = rst_n && (state_q == FILL) && (hrep_q == '0) && load_ok;
    accept      = in_valid && in_ready;
    at_origin   = (row_q == '0) && (col_q == '0);
    frame_start = accept && (at_origin || in_sof);
    scale_in    = SEL_W'(clamp_scale(int'(scale_sel), MAX_SCALE));
  end

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    hrep_d    = hrep_q;
    vrep_d    = vrep_q;
    scale_d   = scale_q;
    pix_d     = pix_q;
    valid_d   = valid_q && !out_ready;
    sof_d     = sof_q;
    eol_d     = eol_q;
    err_d     = err_q;
    col_cur   = col_q;
    row_cur   = row_q;
    scale_cur = scale_q;
    load      = 1'b0;
    load_pix  = rd_data;

    // A frame start (expected or forced by in_sof) restarts the raster and latches a fresh scale.
    if (accept) begin
      load     = 1'b1;
      load_pix = in_pixel;
      if (at_origin ^ in_sof) err_d = 1'b1;
      if (frame_start) begin
        col_cur   = '0;
        row_cur   = '0;
        vrep_d    = '0;
        scale_cur = scale_in;
        scale_d   = scale_in;
      end
    end else if (state_q == REPLAY) begin
      load = load_ok;
    end else if (hrep_q != '0) begin
      load = out_ready;
    end

    hrep_inc = hrep_q + 1'b1;
    wrap     = (hrep_inc == scale_cur);
    line_end = wrap && (col_cur == LAST_COL);

    if (load) begin
      valid_d = 1'b1;
      pix_d   = load_pix;
      sof_d   = frame_start;
      eol_d   = line_end;
      hrep_d  = wrap ? '0 : hrep_inc;
      col_d   = col_cur;
      row_d   = row_cur;
      if (wrap) col_d = line_end ? '0 : col_cur + 1'b1;
      if (line_end) begin
        if (state_q == FILL && scale_cur == SEL_W'(1)) begin
          row_d = (row_cur == LAST_ROW) ? '0 : row_cur + 1'b1;
        end else if (state_q == FILL) begin
          vrep_d  = SEL_W'(1);
          state_d = REPLAY;
        end else if (vrep_q == scale_cur - 1'b1) begin
          vrep_d  = '0;
          row_d   = (row_cur == LAST_ROW) ? '0 : row_cur + 1'b1;
          state_d = FILL;
        end else begin
          vrep_d = vrep_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q   <= '0;
      row_q   <= '0;
      hrep_q  <= '0;
      vrep_q  <= '0;
      scale_q <= '0;
      pix_q   <= '0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      hrep_q  <= hrep_d;
      vrep_q  <= vrep_d;
      scale_q <= scale_d;
      pix_q   <= pix_d;
      valid_q <= valid_d;
      sof_q   <= sof_d;
      eol_q   <= eol_d;
      err_q   <= err_d;
    end
  end

  assign out_pixel = pix_q;
  assign out_valid = valid_q;
  assign out_sof   = sof_q;
  assign out_eol   = eol_q;
  assign sof_err   = err_q;

`ifdef NN_UPSCALER_FRAME_CNT_EN
  logic        frame_end, last_q;
  logic [15:0] cnt_q;

  // The last pixel of a frame is the final copy of the last line generated for the bottom row.
  always_comb begin
    frame_end = line_end && (row_cur == LAST_ROW) &&
                ((state_q == FILL) ? (scale_cur == SEL_W'(1)) : (vrep_q == scale_cur - 1'b1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      if (load) last_q <= frame_end;
      if (frame_done) cnt_q <= cnt_q + 16'd1;
    end
  end

  assign frame_done = valid_q && out_ready && last_q;
  assign frame_cnt  = cnt_q;
`endif

endmodule
